// File: rtl/player_hit_if.sv
// Bundle of frame, drawing-request and hit/status signals between the game
// logic and the player hit controller.
interface player_hit_if;
    logic       startOfFrame;
    logic       playGame;
    logic       playerDrawingRequest;
    logic       missileDrawingRequest;
    logic       alienDrawingRequest;
    logic       playerHit;
    logic       missileHit;
    logic [2:0] livesLeft;
    logic       invulnerable;
    logic       gameOver;

    modport master (
        output startOfFrame, playGame, playerDrawingRequest,
               missileDrawingRequest, alienDrawingRequest,
        input  playerHit, missileHit, livesLeft, invulnerable, gameOver
    );

    modport slave (
        input  startOfFrame, playGame, playerDrawingRequest,
               missileDrawingRequest, alienDrawingRequest,
        output playerHit, missileHit, livesLeft, invulnerable, gameOver
    );
endinterface

// File: rtl/player_hit_controller.sv
// Player hit controller: frame-granular collision detection, lives, immunity and game over.
// Optional macro ALIEN_BODY_HIT_EN makes player/alien body contact a fatal hit.
module player_hit_controller #(
    parameter int unsigned START_LIVES   = 3,
    parameter int unsigned INVULN_FRAMES = 60
) (
    input  logic         clk,
    input  logic         resetN,
    player_hit_if.slave  bus
);

    localparam logic [2:0] LP_START_LIVES = START_LIVES[2:0];
    localparam logic [7:0] LP_INVULN      = INVULN_FRAMES[7:0];

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_INVULN    = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    state_t     r_state;
    logic       r_frame_hit;
    logic [7:0] r_counter;
    logic [2:0] r_lives;
    logic       r_player_hit;
    logic       r_missile_hit;
    logic       r_invuln;
    logic       r_game_over;

    state_t     w_state_nxt;
    logic       w_frame_hit_nxt;
    logic [7:0] w_counter_nxt;
    logic [2:0] w_lives_nxt;
    logic       w_player_hit_nxt;
    logic       w_missile_hit_nxt;
    logic       w_coll;
    logic       w_hit_now;

    assign w_coll    = bus.playGame && bus.playerDrawingRequest && bus.missileDrawingRequest;
    // A collision on the startOfFrame cycle still belongs to the frame that is ending.
    assign w_hit_now = r_frame_hit || w_coll;

`ifdef ALIEN_BODY_HIT_EN
    logic r_alien_hit;
    logic w_alien_hit_nxt;
    logic w_alien_coll;
    logic w_alien_now;

    assign w_alien_coll = bus.playGame && bus.playerDrawingRequest && bus.alienDrawingRequest;
    assign w_alien_now  = r_alien_hit || w_alien_coll;

    // Sticky body-contact flag for the current frame.
    always_comb begin
        w_alien_hit_nxt = r_alien_hit;
        if (!bus.playGame) begin
            w_alien_hit_nxt = 1'b0;
        end else if (bus.startOfFrame) begin
            w_alien_hit_nxt = 1'b0;
        end else if (w_alien_coll) begin
            w_alien_hit_nxt = 1'b1;
        end else begin
            w_alien_hit_nxt = r_alien_hit;
        end
    end

    // Body-contact flag register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_alien_hit <= 1'b0;
        end else begin
            r_alien_hit <= w_alien_hit_nxt;
        end
    end
`endif

    // Next-state, lives, immunity counter and hit pulse decisions.
    always_comb begin
        w_state_nxt       = r_state;
        w_counter_nxt     = r_counter;
        w_lives_nxt       = r_lives;
        w_player_hit_nxt  = 1'b0;
        w_missile_hit_nxt = 1'b0;
        w_frame_hit_nxt   = r_frame_hit;

        if (!bus.playGame) begin
            w_frame_hit_nxt = 1'b0;
        end else if (bus.startOfFrame) begin
            w_frame_hit_nxt = 1'b0;
        end else if (w_coll) begin
            w_frame_hit_nxt = 1'b1;
        end else begin
            w_frame_hit_nxt = r_frame_hit;
        end

        case (r_state)
            ST_IDLE: begin
                w_lives_nxt   = LP_START_LIVES;
                w_counter_nxt = 8'd0;
                if (bus.playGame) begin
                    w_state_nxt = ST_ARMED;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (!bus.playGame) begin
                    w_state_nxt   = ST_IDLE;
                    w_lives_nxt   = LP_START_LIVES;
                    w_counter_nxt = 8'd0;
                end
`ifdef ALIEN_BODY_HIT_EN
                else if (bus.startOfFrame && w_alien_now) begin
                    w_state_nxt      = ST_GAME_OVER;
                    w_lives_nxt      = 3'd0;
                    w_player_hit_nxt = 1'b1;
                end
`endif
                else if (bus.startOfFrame && w_hit_now) begin
                    w_player_hit_nxt  = 1'b1;
                    w_missile_hit_nxt = 1'b1;
                    if (r_lives <= 3'd1) begin
                        w_lives_nxt = 3'd0;
                        w_state_nxt = ST_GAME_OVER;
                    end else begin
                        w_lives_nxt   = r_lives - 3'd1;
                        w_state_nxt   = ST_INVULN;
                        w_counter_nxt = LP_INVULN;
                    end
                end else begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_INVULN: begin
                if (!bus.playGame) begin
                    w_state_nxt   = ST_IDLE;
                    w_lives_nxt   = LP_START_LIVES;
                    w_counter_nxt = 8'd0;
                end else if (bus.startOfFrame) begin
                    // The boundary that consumes the last immune frame re-arms.
                    if (r_counter <= 8'd1) begin
                        w_counter_nxt = 8'd0;
                        w_state_nxt   = ST_ARMED;
                    end else begin
                        w_counter_nxt = r_counter - 8'd1;
                        w_state_nxt   = ST_INVULN;
                    end
                end else begin
                    w_state_nxt = ST_INVULN;
                end
            end
            ST_GAME_OVER: begin
                w_lives_nxt = 3'd0;
                if (!bus.playGame) begin
                    w_state_nxt   = ST_IDLE;
                    w_lives_nxt   = LP_START_LIVES;
                    w_counter_nxt = 8'd0;
                end else begin
                    w_state_nxt = ST_GAME_OVER;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_lives_nxt   = LP_START_LIVES;
                w_counter_nxt = 8'd0;
            end
        endcase
    end

    // State and output registers; reset aborts any immunity or pulse in flight.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= ST_IDLE;
            r_frame_hit   <= 1'b0;
            r_counter     <= 8'd0;
            r_lives       <= LP_START_LIVES;
            r_player_hit  <= 1'b0;
            r_missile_hit <= 1'b0;
            r_invuln      <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_frame_hit   <= w_frame_hit_nxt;
            r_counter     <= w_counter_nxt;
            r_lives       <= w_lives_nxt;
            r_player_hit  <= w_player_hit_nxt;
            r_missile_hit <= w_missile_hit_nxt;
            r_invuln      <= (w_state_nxt == ST_INVULN);
            r_game_over   <= (w_state_nxt == ST_GAME_OVER);
        end
    end

    assign bus.playerHit    = r_player_hit;
    assign bus.missileHit   = r_missile_hit;
    assign bus.livesLeft    = r_lives;
    assign bus.invulnerable = r_invuln;
    assign bus.gameOver     = r_game_over;

endmodule
